// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32 instruction-memory responder.
package rv32_pkg;

   localparam logic [31:0] RV32_NOP = 32'h00000013;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;

   typedef struct packed {
      logic        valid;
      logic [29:0] addr;
   } imem_req_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
      logic [29:0] addr;
      logic        error;
   } imem_rsp_t;

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 program storage: synchronous write, registered read-before-write read.
module imem_array #(
   parameter  int DEPTH = 1024,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_idx,
   output logic [31:0]   rd_data
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   // Same-edge read of a word being written sees the old contents.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)    rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory with WAIT_STATES wait states and stall_fetch.
// Optional IMEM_BOUNDS_CHECK_EN: out-of-range reads return NOP_INSTR with rsp_error.
module imem_responder
   import rv32_pkg::*;
#(
   parameter int          DEPTH       = 1024,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] NOP_INSTR   = RV32_NOP
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   input  logic [29:0] req_addr,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic [29:0] rsp_addr,
   output logic        rsp_error,
   output logic        stall_fetch,
   input  logic        wr_en,
   input  logic [29:0] wr_addr,
   input  logic [31:0] wr_data
);

   localparam int AW = $clog2(DEPTH);

   imem_state_t state, nxt;
   imem_req_t   req;
   imem_rsp_t   rsp;
   logic [3:0]  cnt;
   logic [29:0] lat_addr, rd_addr, rsp_addr_q;
   logic [31:0] arr_data;
   logic        accept, enter_resp, rd_oob, wr_ok, rsp_err_q;

   assign req         = '{valid: req_valid, addr: req_addr};
   assign req_ready   = (state != WAIT);
   assign accept      = req.valid && req_ready;
   assign stall_fetch = (state == WAIT) || (req.valid && !req_ready);

   always_comb begin
      nxt = state;
      case (state)
         IDLE, RESP: nxt = accept ? ((WAIT_STATES == 0) ? RESP : WAIT) : IDLE;
         WAIT:       if (cnt == 4'd1) nxt = RESP;
         default:    nxt = IDLE;
      endcase
   end

   // With zero wait states the array is read straight off the request bus.
   assign enter_resp = (nxt == RESP);
   assign rd_addr    = (state == WAIT) ? lat_addr : req.addr;

`ifdef IMEM_BOUNDS_CHECK_EN
   function automatic logic in_range(input logic [29:0] a);
      return (a >> AW) == 30'd0;
   endfunction
   assign rd_oob = !in_range(rd_addr);
   assign wr_ok  = wr_en && in_range(wr_addr);
`else
   logic unused_wr_hi;
   assign unused_wr_hi = ^wr_addr[29:AW];
   assign rd_oob = 1'b0;
   assign wr_ok  = wr_en;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         cnt        <= '0;
         lat_addr   <= '0;
         rsp_addr_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state <= nxt;
         if (accept) begin
            cnt      <= 4'(WAIT_STATES);
            lat_addr <= req.addr;
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_resp) begin
            rsp_addr_q <= rd_addr;
            rsp_err_q  <= rd_oob;
         end
      end
   end

   imem_array #(.DEPTH(DEPTH)) u_array (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (wr_ok),
      .wr_idx  (wr_addr[AW-1:0]),
      .wr_data (wr_data),
      .rd_en   (enter_resp),
      .rd_idx  (rd_addr[AW-1:0]),
      .rd_data (arr_data)
   );

   assign rsp = '{valid: (state == RESP),
                  data:  rsp_err_q ? NOP_INSTR : arr_data,
                  addr:  rsp_addr_q,
                  error: rsp_err_q};

   assign rsp_valid = rsp.valid;
   assign rsp_data  = rsp.data;
   assign rsp_addr  = rsp.addr;
   assign rsp_error = rsp.error;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: three responders (0, 2, 3 wait states) share one stimulus bus.
module tb_imem_responder;

   localparam int D0 = 0, D2 = 1, D3 = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic [29:0] req_addr;
   logic        wr_en;
   logic [29:0] wr_addr;
   logic [31:0] wr_data;

   logic [2:0]  rdy, vld, err, stall;
   logic [31:0] data  [3];
   logic [29:0] raddr [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   imem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(rdy[D0]), .rsp_valid(vld[D0]), .rsp_data(data[D0]), .rsp_addr(raddr[D0]),
      .rsp_error(err[D0]), .stall_fetch(stall[D0]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

   imem_responder #(.DEPTH(1024), .WAIT_STATES(2)) u_dut2 (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(rdy[D2]), .rsp_valid(vld[D2]), .rsp_data(data[D2]), .rsp_addr(raddr[D2]),
      .rsp_error(err[D2]), .stall_fetch(stall[D2]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

   imem_responder #(.DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(rdy[D3]), .rsp_valid(vld[D3]), .rsp_data(data[D3]), .rsp_addr(raddr[D3]),
      .rsp_error(err[D3]), .stall_fetch(stall[D3]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [29:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      cyc(); cyc();
      resetn = 1'b1;
      cyc();
   endtask

   initial begin
      resetn = 1'b0; req_valid = 1'b0; req_addr = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      cyc(); cyc();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_vld",  vld[k],  1'b0);
         chk("rst_data", data[k], 32'h0);
         chk("rst_err",  err[k],  1'b0);
         chk("rst_rdy",  rdy[k],  1'b1);
      end
      cyc();
      resetn = 1'b1;
      cyc();

      // 1: reset asserted mid-WAIT, no late response
      req_valid = 1'b1; req_addr = 30'd5;
      cyc();
      req_valid = 1'b0;
      @(negedge clk);
      chk("t1_in_wait", stall[D2], 1'b1);
      resetn = 1'b0;
      #1;
      chk("t1_rst_rdy", rdy[D2], 1'b1);
      chk("t1_rst_vld", vld[D2], 1'b0);
      cyc();
      resetn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("t1_no_late_vld", vld[D2], 1'b0);
         cyc();
      end
      @(negedge clk);
      chk("t1_data", data[D2], 32'h0);
      chk("t1_err",  err[D2],  1'b0);
      chk("t1_rdy",  rdy[D2],  1'b1);
      chk("t1_stall", stall[D2], 1'b0);
      cyc();

      // 2: latency with two wait states
      wr(30'd5, 32'hDEADBEEF);
      req_valid = 1'b1; req_addr = 30'd5;
      cyc();
      req_valid = 1'b0;
      req_addr  = 30'd99;
      @(negedge clk);
      chk("t2_c1_stall", stall[D2], 1'b1);
      chk("t2_c1_vld",   vld[D2],   1'b0);
      cyc();
      @(negedge clk);
      chk("t2_c2_stall", stall[D2], 1'b1);
      chk("t2_c2_vld",   vld[D2],   1'b0);
      cyc();
      @(negedge clk);
      chk("t2_c3_vld",   vld[D2],   1'b1);
      chk("t2_c3_data",  data[D2],  32'hDEADBEEF);
      chk("t2_c3_addr",  raddr[D2], 30'd5);
      chk("t2_c3_stall", stall[D2], 1'b0);
      cyc();
      @(negedge clk);
      chk("t2_c4_vld", vld[D2], 1'b0);
      chk("t2_hold_data", data[D2], 32'hDEADBEEF);
      cyc();

      // 3: back-to-back with zero wait states
      for (int i = 0; i < 4; i++) wr(30'(i), 32'hA000_0000 + 32'(i));
      do_reset();
      req_valid = 1'b1; req_addr = 30'd0;
      cyc();
      for (int i = 0; i < 4; i++) begin
         if (i < 3) req_addr = 30'(i + 1);
         else       req_valid = 1'b0;
         @(negedge clk);
         chk("t3_vld",  vld[D0],   1'b1);
         chk("t3_data", data[D0],  32'hA000_0000 + 32'(i));
         chk("t3_addr", raddr[D0], 30'(i));
         chk("t3_rdy",  rdy[D0],   1'b1);
         cyc();
      end
      @(negedge clk);
      chk("t3_end_vld", vld[D0], 1'b0);
      cyc();

      // 4: write lands on the RESP-entry edge of a read of the same word
      wr(30'd7, 32'h1111_1111);
      do_reset();
      req_valid = 1'b1; req_addr = 30'd7;
      cyc();
      req_valid = 1'b0;
      cyc();
      wr(30'd7, 32'h2222_2222);
      @(negedge clk);
      chk("t4_vld",  vld[D2],  1'b1);
      chk("t4_old",  data[D2], 32'h1111_1111);
      req_valid = 1'b1; req_addr = 30'd7;
      cyc();
      req_valid = 1'b0;
      cyc(); cyc();
      @(negedge clk);
      chk("t4_vld2", vld[D2],  1'b1);
      chk("t4_new",  data[D2], 32'h2222_2222);
      cyc();

      // 5: out-of-range address
      do_reset();
      req_valid = 1'b1; req_addr = 30'd1024;
      cyc();
      req_valid = 1'b0;
      @(negedge clk);
      chk("t5_vld",  vld[D0],   1'b1);
      chk("t5_addr", raddr[D0], 30'd1024);
`ifdef IMEM_BOUNDS_CHECK_EN
      chk("t5_data", data[D0], 32'h00000013);
      chk("t5_err",  err[D0],  1'b1);
`else
      chk("t5_data", data[D0], 32'hA000_0000);
      chk("t5_err",  err[D0],  1'b0);
`endif
      cyc();
      wr(30'd1025, 32'h5555_5555);
      req_valid = 1'b1; req_addr = 30'd1;
      cyc();
      req_valid = 1'b0;
      @(negedge clk);
      chk("t5_inrange_err", err[D0], 1'b0);
`ifdef IMEM_BOUNDS_CHECK_EN
      chk("t5_wr_dropped", data[D0], 32'hA000_0001);
`else
      chk("t5_wr_wrapped", data[D0], 32'h5555_5555);
`endif
      cyc();

      // 6: second request arrives during WAIT with three wait states
      wr(30'd9,  32'h0000_0099);
      wr(30'd12, 32'h0000_00CC);
      do_reset();
      req_valid = 1'b1; req_addr = 30'd9;
      cyc();
      req_addr = 30'd12;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t6_wait_rdy",   rdy[D3],   1'b0);
         chk("t6_wait_stall", stall[D3], 1'b1);
         chk("t6_wait_vld",   vld[D3],   1'b0);
         cyc();
      end
      @(negedge clk);
      chk("t6_rsp1_vld",  vld[D3],   1'b1);
      chk("t6_rsp1_data", data[D3],  32'h0000_0099);
      chk("t6_rsp1_addr", raddr[D3], 30'd9);
      chk("t6_rsp1_rdy",  rdy[D3],   1'b1);
      cyc();
      req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t6_gap_vld", vld[D3], 1'b0);
         cyc();
      end
      @(negedge clk);
      chk("t6_rsp2_vld",  vld[D3],   1'b1);
      chk("t6_rsp2_data", data[D3],  32'h0000_00CC);
      chk("t6_rsp2_addr", raddr[D3], 30'd12);
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
